// File: rtl/bitwise_exec_stage_pkg.sv
// Shared types for the bitwise execute stage: operand/opcode/size types,
// the issue-register payload and helpers describing the legal opcode set.
package bitwise_exec_stage_pkg;

   typedef logic [63:0] ulong_t;

   // ADD and SUB belong to the arithmetic unit; they reach this stage only
   // by misrouting and are dropped as illegal.
   typedef enum logic [3:0] {
      OP_NOP    = 4'd0,
      OP_AND    = 4'd1,
      OP_OR     = 4'd2,
      OP_XOR    = 4'd3,
      OP_NOT    = 4'd4,
      OP_ROLR   = 4'd5,
      OP_ROLL   = 4'd6,
      OP_SHIFTR = 4'd7,
      OP_SHIFTL = 4'd8,
      OP_FLIP   = 4'd9,
      OP_ADD    = 4'd10,
      OP_SUB    = 4'd11
   } opcode_t;

   typedef enum logic [1:0] {
      BITS_8  = 2'd0,
      BITS_16 = 2'd1,
      BITS_32 = 2'd2,
      BITS_64 = 2'd3
   } sizeFlags_t;

   typedef struct packed {
      opcode_t    op;
      sizeFlags_t size;
      logic       useCarry;
      ulong_t     a;
      ulong_t     b;
   } issueOp_t;

   // Opcodes this stage executes (NOP included: consumed without a result).
   function automatic logic isBitwiseOp(opcode_t op);
      case (op)
         OP_NOP, OP_AND, OP_OR, OP_XOR, OP_NOT,
         OP_ROLR, OP_ROLL, OP_SHIFTR, OP_SHIFTL, OP_FLIP: return 1'b1;
         default:                                          return 1'b0;
      endcase
   endfunction

   // Index of the most significant bit of the active operand width.
   function automatic logic [5:0] sizeMsb(sizeFlags_t size);
      case (size)
         BITS_8:  return 6'd7;
         BITS_16: return 6'd15;
         BITS_32: return 6'd31;
         default: return 6'd63;
      endcase
   endfunction

   function automatic ulong_t sizeMask(sizeFlags_t size);
      case (size)
         BITS_8:  return 64'h0000_0000_0000_00FF;
         BITS_16: return 64'h0000_0000_0000_FFFF;
         BITS_32: return 64'h0000_0000_FFFF_FFFF;
         default: return 64'hFFFF_FFFF_FFFF_FFFF;
      endcase
   endfunction

endpackage

// File: rtl/bitwise_exec_stage_if.sv
// Issue/result handshake bundle of the bitwise execute stage.
interface bitwise_exec_stage_if #(
   parameter int TAG_W = 5
);
   import bitwise_exec_stage_pkg::*;

   logic             inValid;
   logic             inReady;
   opcode_t          inOp;
   sizeFlags_t       inSize;
   logic             inUseCarry;
   ulong_t           inA;
   ulong_t           inB;
   logic [TAG_W-1:0] inTag;
   logic             flush;
   logic             outValid;
   logic             outReady;
   ulong_t           outResult;
   logic             outCarry;
   logic [TAG_W-1:0] outTag;
   logic             carryFlag;
   logic             illegalOp;

   modport master (
      output inValid, inOp, inSize, inUseCarry, inA, inB, inTag, flush, outReady,
      input  inReady, outValid, outResult, outCarry, outTag, carryFlag, illegalOp
   );

   modport slave (
      input  inValid, inOp, inSize, inUseCarry, inA, inB, inTag, flush, outReady,
      output inReady, outValid, outResult, outCarry, outTag, carryFlag, illegalOp
   );

endinterface

// File: rtl/bitwise_exec_stage_bitwise.sv
// Bitwise: combinational logic/rotate/shift/flip unit. All operations act on
// the low (msb+1) bits selected by size; bits above are returned as zero.
// Rotates and shifts move by b modulo the width; rotates with useCarry go
// through the carry bit, and carryOut is the last bit moved out (carryIn when
// nothing moves or for pure logic ops).
module Bitwise
   import bitwise_exec_stage_pkg::*;
(
   input  opcode_t    op,
   input  sizeFlags_t size,
   input  logic       useCarry,
   input  logic       carryIn,
   input  ulong_t     a,
   input  ulong_t     b,
   output ulong_t     result,
   output logic       carryOut
);

   ulong_t     mask;
   ulong_t     aSized;
   logic [5:0] msb;
   logic [5:0] amount;
   ulong_t     v;
   ulong_t     rev;
   logic       c;
   logic       outBit;
   logic       fill;
   logic       isRot;
   logic       toRight;

   assign mask   = sizeMask(size);
   assign msb    = sizeMsb(size);
   assign aSized = a & mask;
   assign amount = b[5:0] & msb;

   // Evaluate the selected operation within the active width.
   always_comb begin
      // NOTE: every variable gets a default first so no path leaves one unassigned (no latches).
      result   = '0;
      carryOut = carryIn;
      v        = aSized;
      c        = carryIn;
      rev      = {<<{aSized}};
      outBit   = 1'b0;
      fill     = 1'b0;
      isRot    = (op == OP_ROLR) || (op == OP_ROLL);
      toRight  = (op == OP_ROLR) || (op == OP_SHIFTR);
      case (op)
         OP_AND:  result = aSized & b;
         OP_OR:   result = (aSized | b) & mask;
         OP_XOR:  result = (aSized ^ b) & mask;
         OP_NOT:  result = ~aSized & mask;
         OP_FLIP: result = rev >> (6'd63 - msb);
         OP_ROLR, OP_ROLL, OP_SHIFTR, OP_SHIFTL: begin
            // NOTE: blocking updates chain the one-bit steps inside a single evaluation.
            for (int k = 0; k < 63; k++) begin
               if (k < int'(amount)) begin
                  outBit = toRight ? v[0] : v[msb];
                  fill   = isRot ? (useCarry ? c : outBit) : 1'b0;
                  if (toRight) v = (v >> 1) | (ulong_t'(fill) << msb);
                  else         v = ((v << 1) | ulong_t'(fill)) & mask;
                  c = outBit;
               end
            end
            result   = v;
            carryOut = c;
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/bitwise_exec_stage.sv
// Two-register execute stage around Bitwise: stage A holds the issued op,
// stage B holds the registered result. The carry flag is updated as ops move
// A->B, so carry chains run back to back without stalls.
module bitwise_exec_stage
   import bitwise_exec_stage_pkg::*;
#(
   parameter logic CARRY_RESET = 1'b0,
   parameter int   TAG_W       = 5
) (
   input logic                 clk,
   input logic                 resetN,
   bitwise_exec_stage_if.slave bus
);

   logic             aValid;
   issueOp_t         aOp;
   logic [TAG_W-1:0] aTag;
   logic             bValid;
   ulong_t           outResult;
   logic             outCarry;
   logic [TAG_W-1:0] outTag;
   logic             carryFlag;
   logic             illegalOp;
   ulong_t           aluResult;
   logic             aluCarry;
   logic             moveAB;
   logic             accept;
   logic             aLegal;
   logic             aExec;

   assign moveAB      = aValid && (!bValid || bus.outReady);
   assign bus.inReady = !bus.flush && (!aValid || moveAB);
   assign accept      = bus.inValid && bus.inReady;
   assign aLegal      = isBitwiseOp(aOp.op);
   assign aExec       = aLegal && (aOp.op != OP_NOP);

   Bitwise uBitwise (
      .op       (aOp.op),
      .size     (aOp.size),
      .useCarry (aOp.useCarry),
      .carryIn  (carryFlag),
      .a        (aOp.a),
      .b        (aOp.b),
      .result   (aluResult),
      .carryOut (aluCarry)
   );

   // Stage occupancy, carry flag and illegal-op pulse; flush beats any transfer.
   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         aValid    <= 1'b0;
         bValid    <= 1'b0;
         carryFlag <= CARRY_RESET;
         illegalOp <= 1'b0;
      end else if (bus.flush) begin
         aValid    <= 1'b0;
         bValid    <= 1'b0;
         illegalOp <= 1'b0;
      end else begin
         aValid    <= accept || (aValid && !moveAB);
         bValid    <= (moveAB && aExec) || (bValid && !bus.outReady);
         illegalOp <= moveAB && !aLegal;
         if (moveAB && aExec) carryFlag <= aluCarry;
      end
   end

   // Issue register payload, qualified by aValid.
   // NOTE: datapath payload has no reset; the valid bit alone says whether it means anything.
   always_ff @(posedge clk) begin
      if (accept) begin
         aOp  <= '{op: bus.inOp, size: bus.inSize, useCarry: bus.inUseCarry,
                   a: bus.inA, b: bus.inB};
         aTag <= bus.inTag;
      end
   end

   // Result register: loads only on an executed transfer, otherwise holds.
   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         outResult <= '0;
         outCarry  <= 1'b0;
         outTag    <= '0;
      end else if (!bus.flush && moveAB && aExec) begin
         outResult <= aluResult;
         outCarry  <= aluCarry;
         outTag    <= aTag;
      end
   end

   assign bus.outValid  = bValid;
   assign bus.outResult = outResult;
   assign bus.outCarry  = outCarry;
   assign bus.outTag    = outTag;
   assign bus.carryFlag = carryFlag;
   assign bus.illegalOp = illegalOp;

endmodule

// File: tb/tb_bitwise_exec_stage.sv
// Scoreboard bench for bitwise_exec_stage: the driver pushes reference-model
// results at accept time, a monitor pops and compares on every output transfer.
module tb_bitwise_exec_stage;
   import bitwise_exec_stage_pkg::*;

   localparam int   TAG_W     = 5;
   localparam logic CARRY_RST = 1'b1;

   logic clk    = 1'b0;
   logic resetN = 1'b1;
   always #5 clk = ~clk;

   bitwise_exec_stage_if #(.TAG_W(TAG_W)) bus ();

   bitwise_exec_stage #(.CARRY_RESET(CARRY_RST), .TAG_W(TAG_W)) dut (
      .clk    (clk),
      .resetN (resetN),
      .bus    (bus)
   );

   typedef struct {
      ulong_t           result;
      logic             carry;
      logic [TAG_W-1:0] tag;
   } exp_t;

   exp_t   expQ[$];
   int     checks     = 0;
   int     errors     = 0;
   int     expIllegal = 0;
   int     seenIllegal = 0;
   int     acc        = 0;
   logic   mCarry;
   bit     rndReady   = 0;
   ulong_t lastResult = '0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Reference: bit-level definition over a width-w word (plus carry ring).
   function automatic void refOp(input opcode_t op, input sizeFlags_t size, input logic uc,
                                 input logic cin, input ulong_t a, input ulong_t b,
                                 output ulong_t res, output logic cout);
      int   w, n;
      logic ring[65];
      logic rot[65];
      w    = 8 << int'(size);
      n    = int'(b[5:0]) % w;
      res  = '0;
      cout = cin;
      case (op)
         OP_AND:  for (int i = 0; i < w; i++) res[i] = a[i] & b[i];
         OP_OR:   for (int i = 0; i < w; i++) res[i] = a[i] | b[i];
         OP_XOR:  for (int i = 0; i < w; i++) res[i] = a[i] ^ b[i];
         OP_NOT:  for (int i = 0; i < w; i++) res[i] = ~a[i];
         OP_FLIP: for (int i = 0; i < w; i++) res[i] = a[w-1-i];
         OP_SHIFTR: begin
            for (int i = 0; i < w; i++) res[i] = (i + n < w) ? a[i+n] : 1'b0;
            if (n > 0) cout = a[n-1];
         end
         OP_SHIFTL: begin
            for (int i = 0; i < w; i++) res[i] = (i >= n) ? a[i-n] : 1'b0;
            if (n > 0) cout = a[w-n];
         end
         OP_ROLR, OP_ROLL: begin
            if (uc) begin
               for (int i = 0; i < w; i++) ring[i] = a[i];
               ring[w] = cin;
               for (int i = 0; i <= w; i++)
                  rot[i] = (op == OP_ROLR) ? ring[(i + n) % (w + 1)] : ring[(i - n + w + 1) % (w + 1)];
               for (int i = 0; i < w; i++) res[i] = rot[i];
               cout = rot[w];
            end else begin
               for (int i = 0; i < w; i++)
                  res[i] = (op == OP_ROLR) ? a[(i + n) % w] : a[(i - n + w) % w];
               if (n > 0) cout = (op == OP_ROLR) ? res[w-1] : res[0];
            end
         end
         default: ;
      endcase
   endfunction

   // Offer one op, wait for acceptance, then record its expected effect.
   task automatic sendOp(input opcode_t op, input sizeFlags_t size, input logic uc,
                         input ulong_t a, input ulong_t b, input logic [TAG_W-1:0] tag);
      logic   rdy;
      bit     ok;
      ulong_t r;
      logic   c;
      bus.inValid    = 1'b1;
      bus.inOp       = op;
      bus.inSize     = size;
      bus.inUseCarry = uc;
      bus.inA        = a;
      bus.inB        = b;
      bus.inTag      = tag;
      ok = 0;
      for (int cyc = 0; cyc < 200 && !ok; cyc++) begin
         @(negedge clk);
         rdy = bus.inReady;
         @(posedge clk);
         if (rdy) ok = 1;
      end
      if (!ok) check("accept_timeout", 64'(ok), 64'd1);
      else if (int'(op) > 9) expIllegal++;
      else if (op != OP_NOP) begin
         refOp(op, size, uc, mCarry, a, b, r, c);
         expQ.push_back('{r, c, tag});
         mCarry = c;
      end
      #1 bus.inValid = 1'b0;
   endtask

   task automatic drain();
      for (int i = 0; i < 500 && expQ.size() != 0; i++) @(negedge clk);
      if (expQ.size() != 0) check("drain_timeout", 64'(expQ.size()), 64'd0);
      repeat (2) @(negedge clk);
      @(posedge clk);
      #1;
   endtask

   // Monitor: compare each delivered result, verify holding under backpressure.
   ulong_t           hRes;
   logic             hCarry;
   logic [TAG_W-1:0] hTag;
   bit               held = 0;
   always @(negedge clk) begin
      exp_t e;
      if (!resetN) held = 0;
      else begin
         if (bus.illegalOp) seenIllegal++;
         if (held && bus.outValid) begin
            check("hold_result", bus.outResult, hRes);
            check("hold_carry", 64'(bus.outCarry), 64'(hCarry));
            check("hold_tag", 64'(bus.outTag), 64'(hTag));
         end
         held = 0;
         if (bus.outValid) begin
            if (bus.outReady) begin
               if (expQ.size() == 0) check("unexpected_output", 64'(bus.outValid), 64'd0);
               else begin
                  e = expQ.pop_front();
                  check("result", bus.outResult, e.result);
                  check("carry_out", 64'(bus.outCarry), 64'(e.carry));
                  check("tag", 64'(bus.outTag), 64'(e.tag));
                  lastResult = bus.outResult;
               end
            end else begin
               held   = 1;
               hRes   = bus.outResult;
               hCarry = bus.outCarry;
               hTag   = bus.outTag;
            end
         end
      end
   end

   // Random downstream backpressure during the random phase.
   always @(posedge clk) begin
      if (rndReady) #1 bus.outReady = ($urandom_range(0, 3) != 0);
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      logic   saved;
      int     r;
      opcode_t op;
      bus.inValid = 0; bus.inOp = OP_NOP; bus.inSize = BITS_8; bus.inUseCarry = 0;
      bus.inA = '0; bus.inB = '0; bus.inTag = '0; bus.flush = 0; bus.outReady = 0;

      // Asynchronous reset before any clock edge.
      #1 resetN = 1'b0;
      #1;
      check("rst_outValid", 64'(bus.outValid), 64'd0);
      check("rst_inReady", 64'(bus.inReady), 64'd1);
      check("rst_carryFlag", 64'(bus.carryFlag), 64'(CARRY_RST));
      check("rst_outResult", bus.outResult, 64'd0);
      check("rst_outCarry", 64'(bus.outCarry), 64'd0);
      check("rst_outTag", 64'(bus.outTag), 64'd0);
      check("rst_illegalOp", 64'(bus.illegalOp), 64'd0);
      mCarry = CARRY_RST;
      repeat (2) @(negedge clk);
      resetN = 1'b1;
      bus.outReady = 1'b1;
      @(posedge clk);
      #1;

      // AND with two-edge latency, carry untouched.
      sendOp(OP_AND, BITS_64, 1'b0, 64'd3, 64'd1, 5'd1);
      @(negedge clk);
      check("lat_not_yet", 64'(bus.outValid), 64'd0);
      @(negedge clk);
      check("lat_valid", 64'(bus.outValid), 64'd1);
      check("and_result", bus.outResult, 64'd1);
      check("and_carry_kept", 64'(bus.carryFlag), 64'(CARRY_RST));
      drain();

      // Clear carry, then a back-to-back rotate-through-carry chain.
      sendOp(OP_ROLR, BITS_8, 1'b0, 64'd0, 64'd1, 5'd2);
      sendOp(OP_ROLR, BITS_8, 1'b1, 64'd1, 64'd1, 5'd3);
      sendOp(OP_ROLL, BITS_8, 1'b1, 64'h80, 64'd1, 5'd4);
      drain();
      check("chain_result", lastResult, 64'd1);
      check("chain_carry", 64'(bus.carryFlag), 64'd1);

      // Backpressure: only two ops fit while the output is stalled.
      bus.outReady = 1'b0;
      acc = 0;
      fork
         for (int i = 0; i < 4; i++) begin
            sendOp(OP_XOR, BITS_16, 1'b0, {$urandom, $urandom}, {$urandom, $urandom}, 5'(10 + i));
            acc++;
         end
         begin
            repeat (4) @(negedge clk);
            check("bp_inReady", 64'(bus.inReady), 64'd0);
            check("bp_accepts", 64'(acc), 64'd2);
            @(posedge clk);
            #1 bus.outReady = 1'b1;
         end
      join
      drain();

      // Flush with both stages full.
      bus.outReady = 1'b0;
      sendOp(OP_OR, BITS_32, 1'b0, 64'h12, 64'h30, 5'd20);
      sendOp(OP_AND, BITS_32, 1'b0, 64'hF0, 64'h3C, 5'd21);
      bus.flush = 1'b1;
      @(negedge clk);
      check("flush_inReady", 64'(bus.inReady), 64'd0);
      @(posedge clk);
      #1 bus.flush = 1'b0;
      expQ.delete();
      @(negedge clk);
      check("flush_outValid", 64'(bus.outValid), 64'd0);
      check("flush_carry", 64'(bus.carryFlag), 64'(mCarry));
      @(posedge clk);
      #1 bus.outReady = 1'b1;

      // Flush racing a carry-changing A->B transfer: carry must not move.
      saved = mCarry;
      sendOp(OP_ROLR, BITS_8, 1'b0, {63'd0, ~mCarry}, 64'd1, 5'd22);
      bus.flush = 1'b1;
      @(posedge clk);
      #1 bus.flush = 1'b0;
      mCarry = saved;
      expQ.delete();
      @(negedge clk);
      check("flush_mv_outValid", 64'(bus.outValid), 64'd0);
      check("flush_mv_carry", 64'(bus.carryFlag), 64'(mCarry));
      @(posedge clk);
      #1;
      sendOp(OP_XOR, BITS_8, 1'b0, 64'h5A, 64'hFF, 5'd23);
      drain();

      // Illegal op, NOP, then XOR.
      sendOp(opcode_t'(4'd12), BITS_8, 1'b0, 64'd7, 64'd7, 5'd24);
      sendOp(OP_NOP, BITS_8, 1'b0, 64'd7, 64'd7, 5'd25);
      sendOp(OP_XOR, BITS_32, 1'b0, 64'd3, 64'd6, 5'd26);
      drain();
      check("xor_result", lastResult, 64'd5);
      check("illegal_pulses", 64'(seenIllegal), 64'(expIllegal));
      check("nop_carry", 64'(bus.carryFlag), 64'(mCarry));

      // Randomized stream with random backpressure.
      rndReady = 1;
      for (int i = 0; i < 300; i++) begin
         if ($urandom_range(0, 3) == 0) begin
            @(posedge clk);
            #1;
         end
         r = $urandom_range(0, 21);
         if (r < 20) op = opcode_t'(4'(r % 10));
         else        op = opcode_t'(4'($urandom_range(10, 15)));
         sendOp(op, sizeFlags_t'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                {$urandom, $urandom}, {$urandom, $urandom}, 5'($urandom));
      end
      rndReady = 0;
      @(posedge clk);
      #2 bus.outReady = 1'b1;
      drain();
      check("rand_carry", 64'(bus.carryFlag), 64'(mCarry));
      check("rand_illegal", 64'(seenIllegal), 64'(expIllegal));

      // Asynchronous reset mid-stream with carry cleared beforehand.
      sendOp(OP_ROLR, BITS_8, 1'b0, 64'd0, 64'd1, 5'd27);
      drain();
      check("pre_rst_carry", 64'(bus.carryFlag), 64'd0);
      bus.outReady = 1'b0;
      sendOp(OP_XOR, BITS_8, 1'b0, 64'd1, 64'd2, 5'd28);
      sendOp(OP_XOR, BITS_8, 1'b0, 64'd4, 64'd2, 5'd29);
      @(posedge clk);
      #2 resetN = 1'b0;
      #1;
      check("mid_rst_outValid", 64'(bus.outValid), 64'd0);
      check("mid_rst_carry", 64'(bus.carryFlag), 64'd1);
      check("mid_rst_inReady", 64'(bus.inReady), 64'd1);
      check("mid_rst_outResult", bus.outResult, 64'd0);
      expQ.delete();
      mCarry = CARRY_RST;
      @(negedge clk);
      resetN = 1'b1;
      bus.outReady = 1'b1;
      repeat (5) @(negedge clk);
      check("no_stale_output", 64'(bus.outValid), 64'd0);
      @(posedge clk);
      #1;
      sendOp(OP_NOT, BITS_16, 1'b0, 64'h00FF, 64'd0, 5'd30);
      drain();
      check("post_rst_result", lastResult, 64'hFF00);
      check("post_rst_carry", 64'(bus.carryFlag), 64'(mCarry));
      check("final_illegal", 64'(seenIllegal), 64'(expIllegal));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/bitwise_exec_stage.md
BITWISE_EXEC_STAGE -- requirements
Module: bitwise_exec_stage

Interface
REQ-001 Parameter CARRY_RESET, default 1'b0, value loaded into the architectural carry flag on reset.
REQ-002 Parameter TAG_W, default 5, width of the destination-register tag.
REQ-003 Port clk, input, 1, single clock; all state on its rising edge.
REQ-004 Port resetN, input, 1, reset, asynchronous and active-low.
REQ-005 Port inValid, input, 1, upstream offers an operation.
REQ-006 Port inReady, output, 1, stage accepts the operation this cycle.
REQ-007 Port inOp, input, opcode_t, operation (AND, OR, XOR, NOT, ROLR, ROLL, SHIFTR, SHIFTL, FLIP, NOP).
REQ-008 Port inSize, input, sizeFlags_t, operand size (BITS_8/16/32/64).
REQ-009 Port inUseCarry, input, 1, operation consumes the carry flag.
REQ-010 Ports inA and inB, input, ulong_t, operands.
REQ-011 Port inTag, input, TAG_W, destination tag.
REQ-012 Port flush, input, 1, discard all in-flight operations.
REQ-013 Port outValid, output, 1, result available.
REQ-014 Port outReady, input, 1, downstream accepts the result.
REQ-015 Ports outResult (ulong_t), outCarry (1) and outTag (TAG_W), outputs, the registered result, carry-out and tag.
REQ-016 Port carryFlag, output, 1, the architectural carry flag.
REQ-017 Port illegalOp, output, 1, single-cycle pulse when a non-bitwise opcode is dropped.

Function
REQ-018 Pipeline: stage A is the issue register; stage B is the result register; the Bitwise unit sits combinationally between them.
REQ-019 Transfer condition: moveAB = aValid && (!bValid || outReady).
REQ-020 Ready: inReady = !flush && (!aValid || moveAB); full throughput of 1 op/cycle.
REQ-021 Latency: an op accepted on edge N drives outValid after edge N+1 when the path is unstalled.
REQ-022 Carry input: the Bitwise carryIn is carryFlag and useCarry is the stage-A inUseCarry.
REQ-023 Carry update: carryFlag takes the Bitwise carry output on each moveAB of an executed op, so back-to-back carry chains need no stall.
REQ-024 Result width: outResult bits above the selected size are zero.
REQ-025 NOP: a NOP is consumed at moveAB, produces no outValid and leaves carryFlag unchanged.
REQ-026 Illegal opcode: an opcode outside REQ-007 is dropped at moveAB, pulses illegalOp for one cycle and leaves carryFlag unchanged.
REQ-027 Backpressure: while outValid && !outReady, outResult, outCarry and outTag are held stable.
REQ-028 Flush: flush clears aValid and bValid on the next edge and leaves carryFlag unchanged; flush takes priority over a simultaneous moveAB, including its carry update; while flush is high, no op is accepted.
REQ-029 Simultaneous events: when stage B drains (outReady) on the same edge as A moves to B and a new op enters A, all three transfers occur.

Reset
REQ-030 On resetN low, immediately: aValid=0, bValid=0, outValid=0, inReady=1 (once flush is low), illegalOp=0, carryFlag=CARRY_RESET, outResult=0, outCarry=0, outTag=0.
REQ-031 Reset asserted mid-operation discards both stages and does not produce outValid for them.

Structure
REQ-032 opcode_t, sizeFlags_t and ulong_t come from the shared types/instructions packages; the set of legal bitwise opcodes is defined as a package constant function there.
REQ-033 The stage instantiates the existing Bitwise module as its single sub-module; the stage contains no duplicated ALU logic.

Verification
REQ-034 AND a=3, b=1, outReady=1 -> outResult=1 two edges after accept, carryFlag unchanged.
REQ-035 ROLR size=BITS_8, a=1, b=1, useCarry=1, carryFlag=0, then an immediate second op ROLL a=0x80, b=1, useCarry=1 -> first result 0 with carry=1, second result 1 using the forwarded carry.
REQ-036 Stream 4 ops with outReady held low for 3 cycles -> inReady drops after 2 accepts, outputs held stable, all 4 results delivered in order with correct tags.
REQ-037 flush asserted with both stages full -> outValid=0 next cycle, carryFlag unchanged, next accepted op completes normally.
REQ-038 Illegal opcode, then NOP, then XOR a=3, b=6 -> one illegalOp pulse, no output for the first two ops, then outResult=5.
REQ-039 Assert resetN low mid-stream with CARRY_RESET=1 -> outValid=0 and carryFlag=1 asynchronously; no stale result after release.
